nibble_serial_adder_ctrl: RTL and testbench
===========================================

Name: nibble_serial_adder_ctrl

Overview:
Sequencer that performs WIDTH-bit add/subtract by time-multiplexing a single instance of the team's 4-bit ripple adder (Adder4Bit), one nibble per clock, LSB nibble first. A carry register links the nibbles across cycles. The block has a valid/ready request interface and a valid/ready result interface, and sits between the operand source and the result consumer.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise).
NIBBLES, WIDTH/4, derived; number of RUN cycles; not user-overridable.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst_n  in  1  synchronous reset, active-low.
in_valid  in  1  request valid.
in_ready  out  1  controller can accept a request; high only in IDLE.
a  in  WIDTH  operand A; sampled on accept.
b  in  WIDTH  operand B; sampled on accept.
cin  in  1  carry-in for add; ignored when sub=1.
sub  in  1  0: A+B+cin; 1: A+~B+1 (A-B).
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
sum  out  WIDTH  result, registered.
cout  out  1  carry out of the MSB nibble; for sub, 1 means no borrow.
overflow  out  1  two's-complement signed overflow.
busy  out  1  high in RUN or DONE.

Behaviour:
- Reset: rst_n sampled low at a clock edge takes effect at that edge. State goes to IDLE, nibble counter to 0, carry reg to 0, sum=0, cout=0, overflow=0, out_valid=0, busy=0. From the first edge after rst_n rises, in_ready=1.
- Reset mid-operation (RUN or DONE): the operation is discarded. out_valid never asserts for it.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid and in_ready are both high at an edge:
  - capture a;
  - capture b_eff = sub ? ~b : b;
  - carry reg := sub ? 1 : cin;
  - counter := 0; go to RUN.
  - Otherwise stay in IDLE.
- RUN: in_ready=0, busy=1; in_valid is ignored. Each cycle the adder receives nibble[counter] of a and b_eff plus the carry reg.
  - At the edge: sum nibble[counter] := adder sum; carry reg := adder carry-out; counter++.
  - On the edge where counter == NIBBLES-1: cout := adder carry-out; overflow := (a[MSB] == b_eff[MSB]) && (new sum[MSB] != a[MSB]); go to DONE.
- DONE: out_valid=1. sum, cout and overflow are held stable while out_ready=0 (unbounded backpressure). On the edge with out_ready=1, go to IDLE and drop out_valid.
- Latency: accept edge at T; out_valid high from T+NIBBLES; in_ready returns the cycle after the result handshake. There is no accept/output bypass. Minimum spacing between accepts is NIBBLES+2 cycles.
- sum bits not yet written during RUN keep their previous values. out_valid gates their use.
- Arithmetic is modulo 2^WIDTH. The carry out of the MSB appears only on cout and never extends sum.
- in_valid/out_ready asserted during reset: no effect.

Decomposition:
- Shared package, for reuse by later datapath controllers:
  - NIBBLE_W=4;
  - state enum {IDLE, RUN, DONE};
  - counter width function clog2(NIBBLES), minimum 1.
- Sub-module: one instance of Adder4Bit. Nibble mux and write-back live in this block; no further sub-modules.

Test Plan:
- WIDTH=16: a=0x1234, b=0x4321, cin=0, sub=0 accepted at T -> out_valid at T+4; sum=0x5555, cout=0, overflow=0; in_ready low T+1..handshake.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0 (carry ripples through all 4 nibble cycles). a=0x000F, b=0x0000, cin=1 -> sum=0x0010.
- a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, overflow=1, cout=0. Also a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, overflow=1, cout=1.
- sub=1, a=0x0005, b=0x0007, cin=1 (ignored) -> sum=0xFFFE, cout=0, overflow=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> sum/cout/overflow stable, in_ready=0; in_valid with new operands during that window is not accepted. After out_ready=1, in_ready=1 the next cycle and the new request is accepted.
- rst_n=0 for one edge while in RUN with counter=2 -> next cycle state IDLE, in_ready=1, sum=0, out_valid stays 0 for 10 cycles with no request. Then 0x0001+0x0001 -> 0x0002.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for nibble-serial datapath controllers.
// State encoding and counter sizing helper.
package nibble_serial_adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_adder4.sv
// Team 4-bit ripple adder, reused one nibble per cycle.
// Plain combinational sum with carry in and out.
module Adder4Bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign sum  = full[3:0];
  assign cout = full[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract sequenced through one 4-bit adder,
// LSB nibble first, with valid/ready on both sides.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CW = cnt_w(NIBBLES);

  if (WIDTH < NIBBLE_W || (WIDTH % NIBBLE_W) != 0) begin : g_bad
    $error("WIDTH must be a nonzero multiple of 4");
  end

  state_t state, nxt;

  logic [CW-1:0]       cnt;
  logic [CW+1:0]       base;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic                carry;
  logic                last;
  logic [NIBBLE_W-1:0] na;
  logic [NIBBLE_W-1:0] nb;
  logic [NIBBLE_W-1:0] ns;
  logic                nc;

  assign base = {cnt, 2'b00};
  assign last = (cnt == CW'(NIBBLES - 1));
  assign na   = a_q[base +: NIBBLE_W];
  assign nb   = b_q[base +: NIBBLE_W];

  Adder4Bit u_add (
    .a    (na),
    .b    (nb),
    .cin  (carry),
    .sum  (ns),
    .cout (nc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  nxt = RUN;
      RUN:     if (last)      nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (1'b1)
      (state == IDLE): in_ready = 1'b1;
      (state == RUN):  busy = 1'b1;
      (state == DONE): begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Subtract folds into add: invert B and force carry-in to 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry    <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          a_q   <= a;
          b_q   <= sub ? ~b : b;
          carry <= sub | cin;
          cnt   <= '0;
        end
        RUN: begin
          sum[base +: NIBBLE_W] <= ns;
          carry <= nc;
          cnt   <= last ? '0 : cnt + CW'(1);
          if (last) begin
            cout     <= nc;
            overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1])
                     && (ns[NIBBLE_W-1] != a_q[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: vector table through a
// result scoreboard, plus backpressure and mid-run reset.
module tb_nibble_serial_adder_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         busy;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  vec_t tbl[10];

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    a   = v.a;
    b   = v.b;
    cin = v.cin;
    sub = v.sub;
  endtask

  // Called at a negedge; returns at the negedge after accept.
  task automatic accept_op(input vec_t v);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    drive(v);
    in_valid = 1'b1;
    @(posedge clk);
    sb.push_back('{v.sum, v.cout, v.ovf});
    @(negedge clk);
    in_valid = 1'b0;
    chk("in_ready_run", 32'(in_ready), 32'd0);
    chk("busy_run", 32'(busy), 32'd1);
  endtask

  task automatic wait_result();
    int   lat = 0;
    exp_t e;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(NIB));
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("sum", 32'(sum), 32'(e.sum));
      chk("cout", 32'(cout), 32'(e.cout));
      chk("overflow", 32'(overflow), 32'(e.ovf));
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drop", 32'(out_valid), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    vec_t v;

    tbl[0] = '{16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0};
    tbl[1] = '{16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0};
    tbl[2] = '{16'h000F, 16'h0000, 1, 0, 16'h0010, 0, 0};
    tbl[3] = '{16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1};
    tbl[4] = '{16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1};
    tbl[5] = '{16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0};
    tbl[6] = '{16'h0000, 16'h0000, 0, 1, 16'h0000, 1, 0};
    tbl[7] = '{16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1};
    tbl[8] = '{16'hABCD, 16'hABCD, 0, 1, 16'h0000, 1, 0};
    tbl[9] = '{16'h00FF, 16'h0F01, 1, 0, 16'h1001, 0, 0};

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a         = 16'hFFFF;
    b         = 16'hFFFF;
    cin       = 1'b1;
    sub       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      accept_op(tbl[i]);
      wait_result();
      handshake();
    end

    // Backpressure: result must hold and new request must wait.
    accept_op(tbl[0]);
    wait_result();
    v = '{16'h0100, 16'h0200, 0, 0, 16'h0300, 0, 0};
    drive(v);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_sum", 32'(sum), 32'h5555);
      chk("bp_cout", 32'(cout), 32'd0);
      chk("bp_ovf", 32'(overflow), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_ready_after", 32'(in_ready), 32'd1);
    @(posedge clk);
    sb.push_back('{v.sum, v.cout, v.ovf});
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_accepted", 32'(busy), 32'd1);
    wait_result();
    handshake();

    // Reset while in RUN with counter at 2 discards the op.
    accept_op(tbl[1]);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    chk("mr_sum", 32'(sum), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 10; i++) begin
      chk("mr_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    v = '{16'h0001, 16'h0001, 0, 0, 16'h0002, 0, 0};
    accept_op(v);
    wait_result();
    handshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
